ppl_mem_stage: RTL
==================

// Module: ppl_mem_stage
// PURPOSE
// - MEM stage of the pipeline. Consumes the EX/MEM register outputs (m*) and runs
//   loads/stores on a req/ack data-memory bus.
// - Asserts stall to freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
// - Drives the registered MEM/WB outputs (w*) consumed by write-back.
// PARAMETERS
// TIMEOUT   16   max cycles in REQ without dmem_ack before the access is aborted (>=2)
// CNT_W     5    width of the timeout counter; must hold TIMEOUT
// PORTS
// clk          in   1   clock, rising edge
// reset        in   1   asynchronous, active-low reset
// mWriteReg    in   1   M-stage register-write enable
// mMem2Reg     in   1   M-stage load (write-back selects memory data)
// mWriteMem    in   1   M-stage store
// mReg         in   5   M-stage destination register
// mAlu         in   32  M-stage ALU result / byte address
// mDataB       in   32  M-stage store data
// dmem_req     out  1   bus request, registered
// dmem_we      out  1   1 = store, 0 = load; valid while dmem_req
// dmem_addr    out  30  word address = mAlu[31:2]; latched at issue
// dmem_wdata   out  32  store data; latched at issue
// dmem_rdata   in   32  load data; sampled on the cycle dmem_ack=1
// dmem_ack     in   1   single-cycle completion pulse
// stall        out  1   freeze upstream stages (combinational from state and m*)
// err_clr      in   1   clears both sticky error flags
// err_misalign out  1   sticky: a load/store had mAlu[1:0] != 0
// err_timeout  out  1   sticky: an access hit TIMEOUT
// wWriteReg, wMem2Reg  out 1  MEM/WB control
// wReg         out  5   MEM/WB destination register
// wAlu         out  32  MEM/WB ALU result
// wMemData     out  32  MEM/WB load data
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE, counter 0, dmem_req/dmem_we=0, dmem_addr/wdata=0,
//   all w* = 0, both error flags 0. Any in-flight bus access is abandoned without an ack wait.
// - memop = mMem2Reg | mWriteMem. aligned = (mAlu[1:0]==0).
// - IDLE
//   - !memop: W loads m* this edge (wMemData=0). No stall; latency 1.
//   - memop && !aligned: no bus access, err_misalign<=1. W loads a bubble (all w*=0). No stall.
//   - memop && aligned: stall=1. Latch addr/we/wdata and set dmem_req<=1 -> REQ. W loads a bubble.
// - REQ: stall=1, dmem_req held at 1, counter increments each cycle.
//   - dmem_ack=1: capture dmem_rdata, dmem_req<=0 -> DONE.
//   - counter==TIMEOUT-1 && !ack: err_timeout<=1, dmem_req<=0, abort flag set -> DONE.
//   - W loads a bubble every REQ cycle.
// - DONE: stall=0. W loads m* with wMemData = captured data; if the access was aborted,
//   wWriteReg=0. Counter clears -> IDLE. EX/MEM advances on the same edge, so no op re-issues.
// - Minimum load/store: 3 cycles in MEM (IDLE, REQ with ack, DONE); stall high for 2 cycles.
// - dmem_ack outside REQ is ignored.
// - A store still forwards mWriteReg unchanged (normally 0).
// - err_clr and a new error in the same cycle: the error wins (flag = 1).
// - dmem_addr/dmem_wdata/dmem_we hold their last value after the access.
// STRUCTURE
// - Package ppl_defs: state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2), REG_W=5, DATA_W=32.
// - Sub-module ppl_regW: MEM/WB register with a load-or-bubble select and async active-low reset.
// - FSM, counter and bus latches live in ppl_mem_stage.
// TESTING
// 1 ALU op: mWriteReg=1, mReg=5, mAlu=0x1234 -> next edge wReg=5, wAlu=0x1234, wWriteReg=1, stall=0.
// 2 Load at 0x40, ack 2 cycles after req -> dmem_addr=0x10; stall high 3 cycles;
//   wMemData=dmem_rdata and wMem2Reg=1 one edge after DONE; bubbles while stalled.
// 3 Store mAlu=0x80, mDataB=0xDEADBEEF, ack immediate -> dmem_we=1, dmem_wdata=0xDEADBEEF,
//   exactly one dmem_req cycle, stall high 2 cycles.
// 4 Load at 0x42 -> no dmem_req, err_misalign=1, W bubble; err_clr -> flag 0.
// 5 Load, never ack, TIMEOUT=16 -> dmem_req drops after 16 REQ cycles, err_timeout=1,
//   wWriteReg=0, pipeline resumes.
// 6 reset=0 mid-REQ -> dmem_req=0, stall=0, w*=0 immediately; a late ack after release is ignored.

Source files
------------

// File: rtl/ppl_mem_stage_pkg.sv
// ppl_defs: shared MEM-stage types (FSM states, MEM/WB payload).
package ppl_defs;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
  typedef struct packed {
    logic              write_reg;
    logic              mem2reg;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem_data;
  } wb_t;
endpackage

// File: rtl/ppl_mem_stage_if.sv
// ppl_mem_stage_if: req/ack data-memory bus between the MEM stage and memory.
interface ppl_mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ack);
  modport slave (input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ack);
endinterface

// File: rtl/ppl_mem_stage_regw.sv
// ppl_regW: MEM/WB register; loads the stage result or a bubble each cycle.
module ppl_regW
  import ppl_defs::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ld,
  input  wb_t  d,
  output wb_t  q
);
  wb_t wb_d, wb_q;
  always_comb wb_d = ld ? d : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) wb_q <= '0;
    else wb_q <= wb_d;
  assign q = wb_q;
endmodule

// File: rtl/ppl_mem_stage.sv
// ppl_mem_stage: MEM stage; runs loads/stores on the dmem bus and stalls upstream meanwhile.
module ppl_mem_stage
  import ppl_defs::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mWriteReg,
  input  logic              mMem2Reg,
  input  logic              mWriteMem,
  input  logic [REG_W-1:0]  mReg,
  input  logic [DATA_W-1:0] mAlu,
  input  logic [DATA_W-1:0] mDataB,
  ppl_mem_stage_if.master   dmem,
  output logic              stall,
  input  logic              err_clr,
  output logic              err_misalign,
  output logic              err_timeout,
  output logic              wWriteReg,
  output logic              wMem2Reg,
  output logic [REG_W-1:0]  wReg,
  output logic [DATA_W-1:0] wAlu,
  output logic [DATA_W-1:0] wMemData
);
  state_t state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic req_d, req_q, we_d, we_q, abort_d, abort_q, mis_d, mis_q, tmo_d, tmo_q;
  logic [29:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q, rdata_d, rdata_q;
  logic memop, idle, in_req, done, issue, ack, tmo, ld;
  wb_t wb_in, wb_out;
  always_comb begin
    memop   = mMem2Reg | mWriteMem;
    idle    = state_q == IDLE;
    in_req  = state_q == REQ;
    done    = state_q == DONE;
    issue   = idle & memop & (mAlu[1:0] == 2'b00);
    ack     = in_req & dmem.dmem_ack;
    tmo     = in_req & !dmem.dmem_ack & (cnt_q == CNT_W'(TIMEOUT - 1));
    state_d = issue ? REQ : (ack | tmo) ? DONE : done ? IDLE : state_q;
    cnt_d   = in_req ? cnt_q + CNT_W'(1) : '0;
    req_d   = issue | (in_req & !ack & !tmo);
    we_d    = issue ? mWriteMem : we_q;
    addr_d  = issue ? mAlu[31:2] : addr_q;
    wdata_d = issue ? mDataB : wdata_q;
    rdata_d = ack ? dmem.dmem_rdata : rdata_q;
    abort_d = issue ? 1'b0 : tmo ? 1'b1 : abort_q;
    // a new error outranks a clear in the same cycle
    mis_d   = (idle & memop & !issue) | (mis_q & !err_clr);
    tmo_d   = tmo | (tmo_q & !err_clr);
    stall   = in_req | issue;
    ld      = (idle & !memop) | done;
    wb_in.write_reg = mWriteReg & !(done & abort_q);
    wb_in.mem2reg   = mMem2Reg;
    wb_in.rd        = mReg;
    wb_in.alu       = mAlu;
    wb_in.mem_data  = done ? rdata_q : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      abort_q <= 1'b0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
    end
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign err_misalign    = mis_q;
  assign err_timeout     = tmo_q;
  ppl_regW u_regw (.clk(clk), .reset(reset), .ld(ld), .d(wb_in), .q(wb_out));
  assign wWriteReg = wb_out.write_reg;
  assign wMem2Reg  = wb_out.mem2reg;
  assign wReg      = wb_out.rd;
  assign wAlu      = wb_out.alu;
  assign wMemData  = wb_out.mem_data;
endmodule
